// File: rtl/dfr_pkg.sv
// Shared types and default framing constants for the reservoir DAC path.
package dfr_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      LOAD  = 3'd4
   } dac_state_t;

   localparam int unsigned DAC_FRAME_BITS = 16;
   localparam int unsigned DAC_DATA_BITS  = 12;
   localparam logic [3:0]  DAC_CMD        = 4'h3;

endpackage

// File: rtl/dac_spi_driver_if.sv
// Request/handshake and DAC pin bundle between the masking logic and the DAC driver.
interface dac_spi_driver_if
   import dfr_pkg::*;
#(
   parameter int unsigned DATA_BITS = DAC_DATA_BITS
);
   logic [DATA_BITS-1:0] din;
   logic                 start;
   logic                 ready;
   logic                 done;
   logic                 DAC_CS_N;
   logic                 DAC_SCLK;
   logic                 DAC_DIN;
   logic                 DAC_LDAC_N;

   modport master (
      output din, start,
      input  ready, done, DAC_CS_N, DAC_SCLK, DAC_DIN, DAC_LDAC_N
   );

   modport slave (
      input  din, start,
      output ready, done, DAC_CS_N, DAC_SCLK, DAC_DIN, DAC_LDAC_N
   );
endinterface

// File: rtl/dac_sclk_divider.sv
// Half-period timebase: one-cycle half_tick every CLK_DIV cycles while en is high,
// counting from zero again each time en rises.
module dac_sclk_divider #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic half_tick
);
   localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign half_tick = en && (cnt_q == CNT_W'(CLK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (!en || half_tick) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/dac_spi_driver.sv
// Frames {CMD, din}, shifts it MSB-first to the DAC (CPOL=0, DAC samples on SCLK fall),
// then strobes LDAC_N and pulses done. All pin and handshake outputs are registered.
module dac_spi_driver
   import dfr_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned FRAME_BITS  = DAC_FRAME_BITS,
   parameter int unsigned DATA_BITS   = DAC_DATA_BITS,
   parameter logic [31:0] CMD         = 32'(DAC_CMD),
   parameter int unsigned LDAC_CYCLES = 2
) (
   input logic             clk,
   input logic             rst,
   dac_spi_driver_if.slave bus
);
   localparam int unsigned BIT_W = $clog2(FRAME_BITS) + 1;
   localparam int unsigned LD_W  = $clog2(LDAC_CYCLES) + 1;
   // Header bits above DATA_BITS fall off the top, so a full-width din frame carries no CMD.
   localparam logic [FRAME_BITS-1:0] HDR = FRAME_BITS'(CMD) << DATA_BITS;

   dac_state_t            state_q,   state_d;
   logic [FRAME_BITS-1:0] shreg_q,   shreg_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [LD_W-1:0]       ld_cnt_q,  ld_cnt_d;
   logic                  sclk_hi_q, sclk_hi_d;
   logic                  cs_n_q,    cs_n_d;
   logic                  sclk_q,    sclk_d;
   logic                  din_q,     din_d;
   logic                  ldac_n_q,  ldac_n_d;
   logic                  ready_q,   ready_d;
   logic                  done_q,    done_d;
   logic                  half_tick_s;
   logic                  div_en_s;
   logic                  busy_d_s;
   logic [FRAME_BITS-1:0] frame_s;

   assign frame_s  = HDR | FRAME_BITS'(bus.din);
   assign div_en_s = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

   dac_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
      .clk       (clk),
      .rst       (rst),
      .en        (div_en_s),
      .half_tick (half_tick_s)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      ld_cnt_d  = ld_cnt_q;
      sclk_hi_d = sclk_hi_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = SETUP;
               shreg_d   = frame_s;
               bit_cnt_d = BIT_W'(FRAME_BITS - 1);
               sclk_hi_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            if (half_tick_s) begin
               state_d   = SHIFT;
               sclk_hi_d = 1'b1;
            end else begin
               state_d = SETUP;
            end
         end
         SHIFT: begin
            if (!half_tick_s) begin
               state_d = SHIFT;
            end else if (sclk_hi_q) begin
               sclk_hi_d = 1'b0;
            end else if (bit_cnt_q == {BIT_W{1'b0}}) begin
               state_d = HOLD;
            end else begin
               // Next bit goes out together with the SCLK rise.
               shreg_d   = shreg_q << 1;
               bit_cnt_d = bit_cnt_q - BIT_W'(1);
               sclk_hi_d = 1'b1;
            end
         end
         HOLD: begin
            if (half_tick_s) begin
               state_d  = LOAD;
               ld_cnt_d = {LD_W{1'b0}};
            end else begin
               state_d = HOLD;
            end
         end
         LOAD: begin
            if (ld_cnt_q == LD_W'(LDAC_CYCLES - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               ld_cnt_d = ld_cnt_q + LD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy_d_s = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
   assign cs_n_d   = !busy_d_s;
   assign sclk_d   = (state_d == SHIFT) && sclk_hi_d;
   assign din_d    = busy_d_s ? shreg_d[FRAME_BITS-1] : 1'b0;
   assign ldac_n_d = (state_d != LOAD);
   assign ready_d  = (state_d == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= {FRAME_BITS{1'b0}};
         bit_cnt_q <= {BIT_W{1'b0}};
         ld_cnt_q  <= {LD_W{1'b0}};
         sclk_hi_q <= 1'b0;
         cs_n_q    <= 1'b1;
         sclk_q    <= 1'b0;
         din_q     <= 1'b0;
         ldac_n_q  <= 1'b1;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         ld_cnt_q  <= ld_cnt_d;
         sclk_hi_q <= sclk_hi_d;
         cs_n_q    <= cs_n_d;
         sclk_q    <= sclk_d;
         din_q     <= din_d;
         ldac_n_q  <= ldac_n_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   assign bus.DAC_CS_N   = cs_n_q;
   assign bus.DAC_SCLK   = sclk_q;
   assign bus.DAC_DIN    = din_q;
   assign bus.DAC_LDAC_N = ldac_n_q;
   assign bus.ready      = ready_q;
   assign bus.done       = done_q;
endmodule

// File: doc/dac_spi_driver.md
Name: dac_spi_driver

Overview:
Serial DAC front end for the analog reservoir path. It accepts one quantized node-input code per request, frames it with a fixed command header, and shifts the frame MSB-first over a 4-wire DAC interface (CS_N, SCLK, DIN, LDAC_N). It pulses LDAC_N to update the DAC output, then reports completion. It sits directly downstream of the input-masking logic and drives the DAC_* pins that leave the reservoir_asic boundary.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal range is 1 or more.
FRAME_BITS, 16, total bits shifted per transfer.
DATA_BITS, 12, width of the DAC code; must be at most FRAME_BITS.
CMD, 4'h3, command header; occupies the upper FRAME_BITS-DATA_BITS bits of the frame.
LDAC_CYCLES, 2, clk cycles that LDAC_N is held low; legal range is 1 or more.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
din  in  DATA_BITS  DAC code, already quantized upstream
start  in  1  transfer request; honoured only while ready=1
ready  out  1  block idle and able to accept start
done  out  1  one-cycle pulse when a transfer completes
DAC_CS_N  out  1  DAC chip select, active low
DAC_SCLK  out  1  serial clock; CPOL=0, DAC samples DIN on the falling edge
DAC_DIN  out  1  serial data, MSB first
DAC_LDAC_N  out  1  DAC load strobe, active low

Behaviour:
- All outputs are registered. Reset values: CS_N=1, LDAC_N=1, SCLK=0, DIN=0, ready=1, done=0.
- Frame is {CMD, din}, captured into the shift register on the accepting edge. din changes after acceptance have no effect on the transfer.
- FSM states: IDLE, SETUP, SHIFT, HOLD, LOAD.
  - IDLE: ready=1. When start=1, go to SETUP.
  - SETUP: lasts CLK_DIV cycles. CS_N=0, SCLK=0, DIN=frame MSB.
  - SHIFT: FRAME_BITS bit periods, each 2*CLK_DIV cycles.
    - SCLK is high for the first CLK_DIV cycles, low for the second CLK_DIV.
    - DIN is stable for the whole bit period and advances to the next bit when SCLK rises.
  - HOLD: lasts CLK_DIV cycles. CS_N=0, SCLK=0.
  - LOAD: CS_N=1, LDAC_N=0 for LDAC_CYCLES cycles, then go to IDLE with done=1 and ready=1 in that same cycle.
- Timing, with start accepted at edge 0 (T = CLK_DIV*(2*FRAME_BITS+2)):
  - CS_N is low in cycles 1..T.
  - LDAC_N is low in cycles T+1..T+LDAC_CYCLES.
  - done pulses in cycle T+LDAC_CYCLES+1.
  - Defaults: CS_N low in 1..136, LDAC_N low in 137..138, done in 139.
- A start on the done cycle is accepted, giving back-to-back transfers with zero idle gap. CS_N stays high for at least LDAC_CYCLES+1 cycles between frames.
- start while ready=0 is ignored; it is neither queued nor allowed to corrupt the frame.
- rst at any point, including mid-SHIFT, returns the block to IDLE with reset values on the next edge. No done pulse is produced for the aborted frame.
- Counters:
  - Divider counter width is $clog2(CLK_DIV)+1 and reloads at each phase boundary.
  - Bit counter width is $clog2(FRAME_BITS)+1 and counts down; it has no wrap behaviour.
- When DATA_BITS==FRAME_BITS, CMD is unused and the frame is din only.

Decomposition:
- Shared package dfr_pkg holds:
  - the dac_state_t enum (IDLE, SETUP, SHIFT, HOLD, LOAD);
  - default constants DAC_FRAME_BITS=16, DAC_DATA_BITS=12, DAC_CMD=4'h3.
- One sub-module, dac_sclk_divider:
  - inputs clk, rst, en;
  - output a one-cycle half_tick every CLK_DIV cycles;
  - restarts counting when en rises.
- The FSM and shift register stay in dac_spi_driver.

Test Plan:
- Default params, din=12'hABC, single start → frame 16'h3ABC captured MSB-first on 16 SCLK falling edges. CS_N low in cycles 1..136, LDAC_N low in 137..138, done=1 only in cycle 139.
- din=12'h000, then 12'hFFF → DIN shows header 0011 then all 0s / all 1s. SCLK shows exactly 16 rising edges per frame, each high phase 4 cycles.
- start held high continuously → frames repeat every 139 cycles, each start accepted in the done cycle. Changing din during SHIFT does not alter the in-flight frame.
- start pulsed in cycle 50 while busy → ignored: exactly one done pulse, and ready stays 0 until 139.
- rst asserted in cycle 70 (mid-SHIFT) → next cycle CS_N=1, SCLK=0, DIN=0, LDAC_N=1, ready=1, and no done. A new start with din=12'h123 then transfers 16'h3123 correctly.
- CLK_DIV=1, LDAC_CYCLES=1 → SCLK toggles every cycle, CS_N low in cycles 1..34, LDAC_N low in cycle 35, done in cycle 36.
